// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES cipher arbiter.
// The FAULT state exists only when AES_ARB_TIMEOUT_EN is defined.
package aes_arb_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BUSY,
    RESP
`ifdef AES_ARB_TIMEOUT_EN
    ,
    FAULT
`endif
  } state_t;

  typedef struct packed {
    logic [AES_BLK_W-1:0] key;
    logic [AES_BLK_W-1:0] text;
  } req_t;

  // Round-robin pointer advance: id + 1, wrapping at n.
  function automatic int rr_wrap_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping around. Produces a one-hot grant, its encoded id and an any flag.
module aes_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign hi_mask[gi] = (ID_W'(gi) >= ptr);
    end
  endgenerate

  // Prefer requesters at or above the pointer; fall back to the full vector
  // to wrap around, then isolate the lowest set bit.
  assign masked = req & hi_mask;
  assign pick   = (|masked) ? masked : req;
  assign grant  = pick & (~pick + 1'b1);
  assign any    = |req;

  always_comb begin
    id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        id = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/aes_cipher_arbiter.sv
// Shares one AES cipher core between NUM_REQ requesters, round-robin.
// Optional AES_ARB_TIMEOUT_EN: BUSY timeout with error response and sticky FAULT.
module aes_cipher_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_text,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [AES_BLK_W-1:0]           rsp_text,
  output logic                           rsp_err,
  output logic                           busy,
  output logic                           aes_ld,
  output logic [AES_BLK_W-1:0]           aes_key,
  output logic [AES_BLK_W-1:0]           aes_text_in,
  input  logic                           aes_done,
  input  logic [AES_BLK_W-1:0]           aes_text_out
);

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       ptr_reg;
  logic [ID_W-1:0]       id_reg;
  logic [AES_BLK_W-1:0]  key_reg;
  logic [AES_BLK_W-1:0]  text_reg;
  logic [AES_BLK_W-1:0]  rsp_text_reg;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]       arb_id;
  logic                  arb_any;
  logic                  timeout_hit;

  req_t                  req_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_arr[gi] = {req_key[gi*AES_BLK_W +: AES_BLK_W],
                            req_text[gi*AES_BLK_W +: AES_BLK_W]};
    end
  endgenerate

  aes_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .id    (arb_id),
    .any   (arb_any)
  );

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  // Counter restarts on entry to BUSY; the last BUSY cycle is TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == LOAD) begin
        cnt_reg <= '0;
        err_reg <= 1'b0;
      end else if (state_reg == BUSY) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (!aes_done && cnt_reg == CNT_LAST) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign timeout_hit = (cnt_reg == CNT_LAST);
  assign rsp_err     = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      id_reg       <= '0;
      key_reg      <= '0;
      text_reg     <= '0;
      rsp_text_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            key_reg  <= req_arr[arb_id].key;
            text_reg <= req_arr[arb_id].text;
            id_reg   <= arb_id;
          end
        end
        BUSY: begin
          if (aes_done) begin
            rsp_text_reg <= aes_text_out;
          end else if (timeout_hit) begin
            rsp_text_reg <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            ptr_reg <= ID_W'(rr_wrap_inc(int'(id_reg), NUM_REQ));
          end
        end
        default: ;
      endcase
    end
  end

  // Done pulses during LOAD belong to a previous operation and are ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (arb_any) state_next = LOAD;
      LOAD: state_next = BUSY;
      BUSY: begin
        if (aes_done || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
`ifdef AES_ARB_TIMEOUT_EN
          state_next = err_reg ? FAULT : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef AES_ARB_TIMEOUT_EN
      FAULT: state_next = FAULT;
`endif
      default: state_next = IDLE;
    endcase
  end

  assign req_ready   = (state_reg == IDLE && !rst) ? arb_grant : '0;
  assign busy        = (state_reg != IDLE);
  assign aes_ld      = (state_reg == LOAD);
  assign aes_key     = key_reg;
  assign aes_text_in = text_reg;
  assign rsp_valid   = (state_reg == RESP);
  assign rsp_id      = id_reg;
  assign rsp_text    = rsp_text_reg;

endmodule

// File: tb/tb_aes_cipher_arbiter.sv
// Directed bench for aes_cipher_arbiter with a behavioural cipher-core stand-in.
// Build with AES_ARB_TIMEOUT_EN to add the timeout/FAULT sequence.
module tb_aes_cipher_arbiter;
  import aes_arb_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef AES_ARB_TIMEOUT_EN
  localparam int TO  = 8;
  int core_lat = 5;
`else
  localparam int TO  = 64;
  int core_lat = 11;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_key = '0;
  logic [N*128-1:0] req_text = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [IDW-1:0]   rsp_id;
  logic [127:0]     rsp_text;
  logic             rsp_err;
  logic             busy;
  logic             aes_ld;
  logic [127:0]     aes_key;
  logic [127:0]     aes_text_in;
  logic             aes_done = 1'b0;
  logic [127:0]     aes_text_out = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_cipher_arbiter #(
    .NUM_REQ (N),
    .ID_W    (IDW),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key      (req_key),
    .req_text     (req_text),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_text     (rsp_text),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .aes_ld       (aes_ld),
    .aes_key      (aes_key),
    .aes_text_in  (aes_text_in),
    .aes_done     (aes_done),
    .aes_text_out (aes_text_out)
  );

  // Stand-in cipher: real FIPS-197 answer for the known vector, a mixing function otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
  endfunction

  function automatic logic [127:0] mk_key(input int i, input int s);
    return {32'(s), 32'(i), 32'hc0de_0000 + 32'(i), 32'(s * 7 + i)};
  endfunction

  function automatic logic [127:0] mk_text(input int i, input int s);
    return {32'hface_0000 + 32'(i), 32'(s * 3), 32'(i * i + 5), 32'(s) ^ 32'h1234_5678};
  endfunction

  // Core model: done pulse core_lat cycles after ld, optional stale pulse during ld, or hang.
  bit           early_pulse = 1'b0;
  bit           hang        = 1'b0;
  int           core_cnt    = 0;
  logic [127:0] core_key    = '0;
  logic [127:0] core_text   = '0;

  always @(negedge clk) begin
    aes_done = 1'b0;
    if (rst) begin
      core_cnt = 0;
    end else if (aes_ld) begin
      core_key  = aes_key;
      core_text = aes_text_in;
      core_cnt  = hang ? 0 : core_lat;
      if (early_pulse) begin
        aes_done     = 1'b1;
        aes_text_out = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
      end
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        aes_done     = 1'b1;
        aes_text_out = core_fn(core_key, core_text);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_reqs(input int s, input bit fips);
    for (int i = 0; i < N; i++) begin
      req_key[i*128 +: 128]  = mk_key(i, s);
      req_text[i*128 +: 128] = mk_text(i, s);
    end
    if (fips) begin
      req_key[2*128 +: 128]  = FIPS_KEY;
      req_text[2*128 +: 128] = FIPS_PT;
    end
  endtask

  // One complete operation from grant to consumed response.
  task automatic run_txn(input logic [N-1:0] mask, input int exp_id, input int seed,
                         input bit fips, input bit early, input bit keep);
    logic [N-1:0] eg;
    logic [127:0] ek, et;
    int k;
    bit ok;
    eg = 4'b0001 << exp_id;
    early_pulse = early;
    set_reqs(seed, fips);
    req_valid = mask;
    #1;
    chk("grant", req_ready, eg);
    chk("idle_at_grant", busy, 1'b0);
    ek = req_key[exp_id*128 +: 128];
    et = req_text[exp_id*128 +: 128];
    @(negedge clk);
    if (!keep) req_valid = '0;
    #1;
    early_pulse = 1'b0;
    chk("ld", aes_ld, 1'b1);
    chk("aes_key", aes_key, ek);
    chk("aes_text_in", aes_text_in, et);
    chk("no_ready_in_load", req_ready, '0);
    ok = 1'b1;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      #1;
      k++;
      if (aes_ld || req_ready != '0 || !busy) ok = 1'b0;
      if (rsp_valid) break;
    end
    chk("single_ld_no_ready", ok, 1'b1);
    chk("latency", k, core_lat + 1);
    chk("rsp_id", rsp_id, exp_id);
    chk("rsp_text", rsp_text, core_fn(ek, et));
    chk("rsp_err", rsp_err, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", busy, 1'b0);
    $display("txn id=%0d mask=%b latency=%0d text=%h", exp_id, mask, k, rsp_text);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_id"}, rsp_id, '0);
    chk({tag, "_rsp_text"}, rsp_text, '0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_aes_ld"}, aes_ld, 1'b0);
    chk({tag, "_aes_key"}, aes_key, '0);
    chk({tag, "_aes_text_in"}, aes_text_in, '0);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           exp_id;
    bit           fips;
    bit           early;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [127:0] exp_txt;
    int k;
    bit ok;

    // Pointer walk: 0 -> 3 -> 0 -> 2 -> 1 -> 0 -> 2 -> 1 -> 3
    tbl[0] = '{4'b0100, 2, 1'b1, 1'b0};
    tbl[1] = '{4'b1111, 3, 1'b0, 1'b0};
    tbl[2] = '{4'b0110, 1, 1'b0, 1'b0};
    tbl[3] = '{4'b0011, 0, 1'b0, 1'b1};
    tbl[4] = '{4'b1001, 3, 1'b0, 1'b0};
    tbl[5] = '{4'b1010, 1, 1'b0, 1'b0};
    tbl[6] = '{4'b0001, 0, 1'b0, 1'b0};
    tbl[7] = '{4'b0100, 2, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_txn(tbl[v].mask, tbl[v].exp_id, v, tbl[v].fips, tbl[v].early, 1'b0);
    end

    // Response stall: 20 cycles with rsp_ready low and all requesters pushing.
    set_reqs(20, 1'b0);
    req_valid = 4'b0010;
    exp_txt = core_fn(mk_key(1, 20), mk_text(1, 20));
    #1;
    chk("stall_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    k = 0;
    while (k < 100 && !rsp_valid) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("stall_rsp_seen", rsp_valid, 1'b1);
    req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      chk("stall_ctrl", {rsp_valid, busy, req_ready, rsp_id, rsp_err},
          {1'b1, 1'b1, 4'b0000, 2'd1, 1'b0});
      chk("stall_text", rsp_text, exp_txt);
    end
    $display("stall held 20 cycles id=%0d text=%h", rsp_id, rsp_text);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    rsp_ready = 1'b0;

    // Reset while BUSY: request dropped, pointer back to requester 0.
    set_reqs(30, 1'b0);
    req_valid = 4'b0100;
    #1;
    chk("rst_case_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_case_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid || busy) ok = 1'b0;
    end
    chk("no_rsp_after_rst", ok, 1'b1);
    $display("mid-operation reset dropped request");

    // Continuous load from all requesters: order 0,1,2,3,0.
    run_txn(4'b1111, 0, 40, 1'b0, 1'b0, 1'b1);
    run_txn(4'b1111, 1, 40, 1'b0, 1'b0, 1'b1);
    run_txn(4'b1111, 2, 40, 1'b0, 1'b0, 1'b1);
    run_txn(4'b1111, 3, 40, 1'b0, 1'b0, 1'b1);
    run_txn(4'b1111, 0, 40, 1'b0, 1'b0, 1'b1);
    req_valid = '0;

`ifdef AES_ARB_TIMEOUT_EN
    // Core never finishes: error response after TO BUSY cycles, then sticky FAULT.
    hang = 1'b1;
    set_reqs(50, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("to_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      #1;
      k++;
      if (rsp_valid) break;
    end
    chk("to_latency", k, TO + 1);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_text", rsp_text, '0);
    chk("to_rsp_id", rsp_id, '0);
    $display("timeout rsp id=%0d err=%0d after %0d cycles", rsp_id, rsp_err, k);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (req_ready != '0 || !busy || rsp_valid) ok = 1'b0;
    end
    chk("fault_sticky", ok, 1'b1);
    req_valid = '0;
    hang = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs("fault_rst");
    run_txn(4'b1111, 0, 60, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
